d_ff: RTL and testbench



---
 rtl/d_ff.sv | 87 ++++++++
 tb/tb_d_ff.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// Parameterised synchronous-reset D register / delay line with true and complement outputs.
// Define D_FF_ASSERT_EN to compile in simulation-only X/consistency checks.
module d_ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter int unsigned           STAGES  = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             Rst,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Delay line: reset flushes every stage in the same edge, otherwise shift D in.
  always_ff @(posedge clk) begin
    if (Rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= D;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign Q  = stage_r[STAGES-1];
  // Complement is derived from Q so the two can never disagree.
  assign Qb = ~Q;

`ifdef D_FF_ASSERT_EN
  d_ff_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk (clk),
    .rst (Rst),
    .d   (D),
    .q   (Q),
    .qb  (Qb)
  );
`endif

endmodule

`ifdef D_FF_ASSERT_EN
// Simulation-only sanity checks on the register's inputs and outputs.
module d_ff_checker #(
  parameter int unsigned WIDTH = 1
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] d,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] qb
);

  logic seen_reset_r = 1'b0;

  // Output consistency only becomes meaningful once a reset has defined the state.
  always_ff @(posedge clk) begin
    if (rst === 1'b1) begin
      seen_reset_r <= 1'b1;
    end else begin
      seen_reset_r <= seen_reset_r;
    end
  end

  // Flag unknown control/data at the sampling edge and any Q/Qb disagreement.
  always @(posedge clk) begin
    if ($isunknown(rst)) begin
      $error("d_ff: Rst unknown at time %0t, Rst=%b", $time, rst);
    end else if (rst === 1'b0 && $isunknown(d)) begin
      $error("d_ff: D unknown with Rst=0 at time %0t, D=%b", $time, d);
    end else begin
    end
    if (seen_reset_r && (qb !== ~q)) begin
      $error("d_ff: Qb != ~Q at time %0t, Q=%b Qb=%b", $time, q, qb);
    end else begin
    end
  end

endmodule
`endif

// File: tb/tb_d_ff.sv
// Self-checking bench: a default 1-bit flop and an 8-bit 3-stage delay line against a history-window model.
module tb_d_ff;

  localparam int          W1  = 8;
  localparam int          S1  = 3;
  localparam logic [7:0]  RV1 = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          d0  = 1'b0;
  logic [W1-1:0] d1  = '0;
  logic          q0, qb0;
  logic [W1-1:0] q1, qb1;

  int n_cmp = 0;
  int n_err = 0;

  // Everything sampled at each rising edge, oldest first.
  bit         rst_h[$];
  logic       d0_h[$];
  logic [7:0] d1_h[$];

  d_ff u_dut0 (
    .D   (d0),
    .clk (clk),
    .Rst (rst),
    .Q   (q0),
    .Qb  (qb0)
  );

  d_ff #(
    .WIDTH   (W1),
    .STAGES  (S1),
    .RST_VAL (RV1)
  ) u_dut1 (
    .D   (d1),
    .clk (clk),
    .Rst (rst),
    .Q   (q1),
    .Qb  (qb1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Q after the latest edge: RST_VAL if any of the last S edges saw reset,
  // else the D sampled S-1 edges ago; unknown if the window predates the history.
  function automatic logic [63:0] model_q(input int s, input logic [63:0] rv,
                                          input bit wide, output bit valid);
    int n = rst_h.size();
    valid = 1'b0;
    model_q = '0;
    for (int k = 0; k < s && k < n; k++) begin
      if (rst_h[n-1-k]) begin
        valid = 1'b1;
        return rv;
      end
    end
    if (n >= s) begin
      valid = 1'b1;
      model_q = wide ? {56'd0, d1_h[n-s]} : {63'd0, d0_h[n-s]};
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [63:0] e0, e1;
    bit v0, v1;
    e0 = model_q(1, 64'd0, 1'b0, v0);
    e1 = model_q(S1, {56'd0, RV1}, 1'b1, v1);
    if (v0) begin
      check_eq({tag, ".q0"},  {63'd0, q0},  e0);
      check_eq({tag, ".qb0"}, {63'd0, qb0}, {63'd0, ~e0[0]});
    end
    if (v1) begin
      check_eq({tag, ".q1"},  {56'd0, q1},  e1);
      check_eq({tag, ".qb1"}, {56'd0, qb1}, {56'd0, ~e1[7:0]});
    end
  endtask

  task automatic edge_and_check(input string tag);
    @(posedge clk);
    rst_h.push_back(rst);
    d0_h.push_back(d0);
    d1_h.push_back(d1);
    #1;
    check_outputs(tag);
  endtask

  task automatic step(input string tag, input logic r, input logic a, input logic [7:0] b);
    @(negedge clk);
    rst = r;
    d0  = a;
    d1  = b;
    edge_and_check(tag);
  endtask

  initial begin
    // Reset held for two edges.
    step("rst0", 1'b1, 1'b0, 8'h00);
    step("rst1", 1'b1, 1'b0, 8'h00);
    // Release with data; the wide line shows A5 for two more edges.
    step("rel_d1", 1'b0, 1'b1, 8'h01);
    step("d0",     1'b0, 1'b0, 8'h02);
    step("d1b",    1'b0, 1'b1, 8'h03);
    step("pipe1",  1'b0, 1'b1, 8'h04);
    step("pipe2",  1'b0, 1'b0, 8'h05);

    // Glitches between edges: only the value at the edge counts, Q holds meanwhile.
    @(negedge clk);
    d0 = 1'b1; #1 d0 = 1'b0; #1 d0 = 1'b1; #1 d0 = 1'b0; #1 d0 = 1'b1;
    d1 = 8'h3C;
    check_outputs("glitch_hold");
    edge_and_check("glitch_edge");

    // Reset asserted while Q=1: no effect until the edge, and D=1 is discarded.
    @(negedge clk);
    rst = 1'b1;
    d0  = 1'b1;
    d1  = 8'hFF;
    #1 check_outputs("rst_before_edge");
    edge_and_check("rst_mid");
    // X on D during reset must not propagate.
    step("rst_x", 1'b1, 1'bx, 8'hxx);
    step("post_x0", 1'b0, 1'b1, 8'h11);
    step("post_x1", 1'b0, 1'b0, 8'h22);
    step("post_x2", 1'b0, 1'b1, 8'h33);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
